// File: rtl/fft_fifo_uart_pkg.sv
// Shared constants, FSM state type and byte-select helper
// for the test-wave FIFO to UART streaming block.
package fft_fifo_uart_pkg;

   localparam int DEF_CLK_FREQ     = 50_000_000;
   localparam int DEF_BAUD         = 115_200;
   localparam int DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD;
   localparam int DEF_SAMPLE_W     = 14;
   localparam int DEF_FRAME_LEN    = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_SEND
   } state_e;

   function automatic logic [7:0] pick_byte(
      input logic [15:0] i_word,
      input logic        i_lo
   );
      return i_lo ? i_word[7:0] : i_word[15:8];
   endfunction

endpackage

// File: rtl/fft_fifo_uart_tx.sv
// UART 8N1 transmitter: LSB first, idle high,
// start accepted only while not busy.
module uart_tx_8n1
   import fft_fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_tx
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);

   logic          r_busy;
   logic          r_tx;
   logic [8:0]    r_shift;
   logic [3:0]    r_bit;
   logic [CW-1:0] r_clk;

   // shift holds data then stop bit; start bit is driven on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_tx    <= 1'b1;
         r_shift <= '1;
         r_bit   <= '0;
         r_clk   <= '0;
      end else if (!r_busy) begin
         if (i_start) begin
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
            r_shift <= {1'b1, i_data};
            r_bit   <= '0;
            r_clk   <= '0;
         end
      end else if (r_clk == CW'(CLKS_PER_BIT - 1)) begin
         r_clk <= '0;
         if (r_bit == 4'd9) begin
            r_busy <= 1'b0;
            r_tx   <= 1'b1;
         end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b1, r_shift[8:1]};
            r_bit   <= r_bit + 4'd1;
         end
      end else begin
         r_clk <= r_clk + 1'b1;
      end
   end

   assign o_busy = r_busy;
   assign o_tx   = r_tx;

endmodule

// File: rtl/fft_fifo_uart_top.sv
// Test-wave source fills a frame FIFO which is then streamed
// to the host as big-endian 16-bit words over UART.
module fft_fifo_uart_top
   import fft_fifo_uart_pkg::*;
#(
   parameter int CLK_FREQ  = DEF_CLK_FREQ,
   parameter int BAUD      = DEF_BAUD,
   parameter int SAMPLE_W  = DEF_SAMPLE_W,
   parameter int FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_ready,
   output logic tx_ready,
   output logic tx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int AW = $clog2(FRAME_LEN);

   state_e              r_state;
   state_e              w_next;
   logic                r_rx_s1;
   logic                r_rx_s2;
   logic                r_tx_ready;
   logic                r_lo;
   logic [AW-1:0]       r_phase;
   logic [AW-1:0]       r_wr;
   logic [AW-1:0]       r_rd;
   logic [AW:0]         r_cnt;
   logic [SAMPLE_W-1:0] r_mem [FRAME_LEN];

   logic                w_push;
   logic                w_pop;
   logic                w_start;
   logic                w_busy;
   logic                w_empty;
   logic [SAMPLE_W-1:0] w_sample;
   logic [SAMPLE_W-1:0] w_rd_sample;
   logic [15:0]         w_word;
   logic [7:0]          w_byte;

   assign w_empty     = (r_cnt == '0);
   assign w_sample    = {r_phase[5:0], {(SAMPLE_W - 6){1'b0}}};
   assign w_rd_sample = r_mem[r_rd];
   assign w_word      = {{(16 - SAMPLE_W){w_rd_sample[SAMPLE_W-1]}},
                         w_rd_sample};
   assign w_byte      = pick_byte(w_word, r_lo);
   assign w_pop       = w_start && r_lo;

   always_comb begin
      w_next  = r_state;
      w_push  = 1'b0;
      w_start = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_rx_s2) w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_push = 1'b1;
            if (r_phase == AW'(FRAME_LEN - 1)) w_next = S_SEND;
         end
         S_SEND: begin
            w_start = r_rx_s2 && !w_busy && !w_empty;
            if (w_empty && !w_busy) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rx_s1    <= 1'b0;
         r_rx_s2    <= 1'b0;
         r_tx_ready <= 1'b1;
         r_lo       <= 1'b0;
         r_phase    <= '0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_next;
         r_rx_s1    <= rx_ready;
         r_rx_s2    <= r_rx_s1;
         r_tx_ready <= (w_next == S_IDLE);
         if (r_state == S_IDLE) r_phase <= '0;
         else if (w_push) r_phase <= r_phase + 1'b1;
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         if (w_start) r_lo <= !r_lo;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push}
                        - {{AW{1'b0}}, w_pop};
      end
   end

   // sample storage carries no reset; occupancy is tracked by r_cnt
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_sample;
   end

   uart_tx_8n1 #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_start(w_start),
      .i_data (w_byte),
      .o_busy (w_busy),
      .o_tx   (tx)
   );

   assign tx_ready = r_tx_ready;

endmodule

// File: tb/tb_fft_fifo_uart_top.sv
// Directed bench: UART-decodes frames and checks bytes,
// bit timing, flow control, back-to-back frames and reset.
module tb_fft_fifo_uart_top;

   localparam int CF  = 500_000;
   localparam int BD  = 100_000;
   localparam int CPB = CF / BD;
   localparam int TMO = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_ready = 1'b0;
   logic tx_ready;
   logic tx;

   int n_vec = 0;
   int n_err = 0;

   fft_fifo_uart_top #(
      .CLK_FREQ (CF),
      .BAUD     (BD),
      .SAMPLE_W (14),
      .FRAME_LEN(64)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_ready(rx_ready),
      .tx_ready(tx_ready),
      .tx      (tx)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_byte(input bit drop, output logic [7:0] d,
                          output int gap, output int lowrun,
                          output bit ok, output bit rdy);
      logic bv;
      bit inlow;
      d = '0; gap = 0; lowrun = 0; ok = 1'b1; rdy = 1'b0;
      inlow = 1'b1; bv = 1'b1;
      @(negedge clk);
      while (tx !== 1'b0 && gap < TMO) begin
         gap++;
         if (tx_ready !== 1'b0) rdy = 1'b1;
         @(negedge clk);
      end
      if (tx !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < CPB; c++) begin
            if (c == 0) bv = tx;
            else if (tx !== bv) ok = 1'b0;
            if (inlow && tx === 1'b0) lowrun++;
            else inlow = 1'b0;
            if (tx_ready !== 1'b0) rdy = 1'b1;
            if (drop && k == 0 && c == 0) rx_ready = 1'b0;
            if (c == 0) begin
               if (k == 0 && bv !== 1'b0) ok = 1'b0;
               if (k == 9 && bv !== 1'b1) ok = 1'b0;
               if (k >= 1 && k <= 8) d[k-1] = bv;
            end
            if (!(k == 9 && c == CPB - 1)) @(negedge clk);
         end
      end
   endtask

   task automatic start_frame(input string tag);
      int n;
      n = 0;
      rx_ready = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (tx_ready !== 1'b0 && n < 10);
      chk({tag, "_rdy_fall_lat"}, n, 3);
   endtask

   task automatic rx_frame(input string tag, input int drop_i,
                           input int pause_i);
      logic [7:0] d, e;
      int gap, lr, lows;
      bit ok, rdy;
      for (int i = 0; i < 128; i++) begin
         rx_byte(i == drop_i || i == pause_i, d, gap, lr, ok, rdy);
         e = (i % 2 == 1) ? 8'h00 : {{2{i[6]}}, i[6:1]};
         chk({tag, "_data"}, d, e);
         chk({tag, "_bits"}, ok, 1);
         chk({tag, "_txrdy_low"}, rdy, 0);
         if (i == 0)
            chk({tag, "_first_lat"}, gap >= 63 && gap <= 66, 1);
         else if (i != pause_i + 1)
            chk({tag, "_gap"}, gap <= 2, 1);
         if (i == 2) chk({tag, "_start_w"}, lr, CPB);
         if (i == pause_i) begin
            lows = 0;
            repeat (30 * CPB) begin
               @(negedge clk);
               if (tx !== 1'b1) lows++;
            end
            chk({tag, "_pause_idle"}, lows, 0);
            chk({tag, "_pause_rdy"}, tx_ready, 0);
            rx_ready = 1'b1;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int n, bad;
      n = 0;
      bad = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_ready !== 1'b1 && n < 10);
      chk({tag, "_rdy_rise_lat"}, n, 2);
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_ready !== 1'b1) bad++;
      end
      chk({tag, "_quiet"}, bad, 0);
   endtask

   initial begin
      logic [7:0] d;
      int gap, lr, n, hi, bad;
      bit ok, rdy;

      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_txrdy", tx_ready, 1);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_ready !== 1'b1) bad++;
      end
      chk("post_rst_quiet", bad, 0);

      start_frame("single");
      rx_frame("single", 127, -1);
      wait_idle("single");

      start_frame("flow");
      rx_frame("flow", 127, 5);
      wait_idle("flow");

      start_frame("cont");
      rx_frame("cont1", -1, -1);
      n = 0;
      hi = 0;
      do begin
         @(negedge clk);
         n++;
         if (tx_ready === 1'b1) hi++;
      end while (!(hi > 0 && tx_ready === 1'b0) && n < 10);
      chk("cont_idle_pulse", hi, 1);
      rx_frame("cont2", 127, -1);
      wait_idle("cont");

      start_frame("mid");
      for (int i = 0; i < 3; i++) begin
         rx_byte(1'b0, d, gap, lr, ok, rdy);
         chk("mid_data", d, (i == 2) ? 8'h01 : 8'h00);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx !== 1'b0 && n < TMO);
      chk("mid_byte_start", tx, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      rx_ready = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_txrdy", tx_ready, 1);
      repeat (3) @(negedge clk);
      chk("mid_rst_hold_tx", tx, 1);
      rst_n = 1'b1;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_ready !== 1'b1) bad++;
      end
      chk("mid_rst_quiet", bad, 0);

      start_frame("post");
      rx_frame("post", 127, -1);
      wait_idle("post");

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fft_fifo_uart_top.md
# fft_fifo_uart_top

Top-level streaming block of the spectrum-demo design: an internal deterministic test-wave source fills a frame FIFO, and the frame is serialised to a host over a UART transmit line. The host gates transfers with a level `rx_ready` flag; the block reports idle/accepting state on `tx_ready`. The block sits directly on the board clock and pins.

## Interface
- `CLK_FREQ`, 50_000_000: input clock frequency in Hz (20 ns period).
- `BAUD`, 115200: UART bit rate; `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer truncation (434).
- `SAMPLE_W`, 14: test-wave sample width, signed.
- `FRAME_LEN`, 64: samples per frame; FIFO depth equals `FRAME_LEN`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_ready`  in  1  host ready/request level; async to nothing (treated as `clk`-domain, 2-flop synchronised).
- `tx_ready`  out  1  high when block is idle and will accept a new frame request.
- `tx`  out  1  UART 8N1 serial data, idle high.

## Operation
- FSM states: IDLE, CAPTURE, SEND.
- IDLE: `tx_ready`=1. On synchronised `rx_ready`=1 → CAPTURE; phase counter cleared to 0.
- CAPTURE: one sample written to FIFO per cycle for `FRAME_LEN` cycles. Sample n = 14-bit two's-complement `{phase[5:0], 8'b0}`, phase = n. Values: 0x0000, 0x0100 … 0x1F00, 0x2000 (−8192) … 0x3F00. Then → SEND. Every frame identical.
- SEND: each FIFO entry sign-extended to 16 bits, sent high byte then low byte (sample 32 → bytes 0xE0, 0x00). A new byte starts only when synchronised `rx_ready`=1 and UART idle; a byte in flight always completes. When FIFO empty and last stop bit done → IDLE.
- UART: 8N1, LSB first, start 0, stop 1, each bit `CLKS_PER_BIT` cycles; byte = 10 bit periods.
- `rx_ready` held high continuously → back-to-back frames with one IDLE cycle between them.
- FIFO never overflows (writes only in CAPTURE, starting empty); a pop on empty cannot occur.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, FSM=IDLE, FIFO empty, phase=0. Async assert; deassert takes effect at next `clk` edge.
- `rx_ready` synchroniser: 2 cycles; IDLE→CAPTURE on the edge after the synchronised level is seen; `tx_ready` falls on that same edge (registered).
- CAPTURE lasts exactly `FRAME_LEN` cycles.
- First start bit on `tx` ≤3 cycles after CAPTURE ends (given `rx_ready`=1).
- Inter-byte gap with `rx_ready`=1: ≤2 cycles of idle-high between stop bit and next start bit.
- Full frame ≈ 2·`FRAME_LEN`·10·`CLKS_PER_BIT` cycles (555,520 at defaults, plus gaps).
- `tx_ready` rises the cycle after final stop bit ends.
- Reset mid-frame: `tx` forced high immediately, FIFO flushed, no partial byte resumes.

## Structure
- Shared package: `CLKS_PER_BIT`, sample width, frame length, FSM state enum.
- Natural sub-module: `uart_tx_8n1` (byte in, `start`/`busy`, `tx` out). FIFO, wave source and FSM stay inline in the top.

## Test plan
- Reset: assert `rst_n`=0 mid-run → `tx`=1, `tx_ready`=1 while low; no activity after release with `rx_ready`=0.
- Single frame: pulse `rx_ready` high to end of frame → 128 bytes decoded: 0x00,0x00, 0x01,0x00 … 0x1F,0x00, 0xE0,0x00 … 0xFF,0x00; `tx_ready` low throughout, high after.
- Bit timing: measure start bit width = 434 cycles (8680 ns) ±0; stop bit high 434 cycles.
- Flow control: drop `rx_ready` mid-byte 5 → byte 5 completes, `tx` stays high; raise again → byte 6 resumes, no data lost or duplicated.
- Continuous `rx_ready`=1 → two consecutive identical 128-byte frames, `tx_ready` high exactly one cycle between them.
